div_iter_axis: RTL and testbench
================================

# div_iter_axis

Iterative radix-2 divider core exposing the same AXI-stream dividend/divisor/dout channel set as the vendor divider IP, so the EX-stage divide wrapper can drive it in place of that IP. It accepts one dividend beat and one divisor beat, runs a fixed-latency restoring shift-subtract loop, and presents {quotient, remainder} on a master stream held under backpressure. Signed and unsigned operation is selected per operation by a sideband bit.

## Interface
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- s_axis_dividend_tvalid  in  1  dividend beat valid
- s_axis_dividend_tready  out  1  dividend channel ready
- s_axis_dividend_tdata  in  WIDTH  dividend
- s_axis_dividend_tuser  in  1  div_signed; 1 = two's-complement operation, captured with the dividend beat
- s_axis_divisor_tvalid  in  1  divisor beat valid
- s_axis_divisor_tready  out  1  divisor channel ready
- s_axis_divisor_tdata  in  WIDTH  divisor
- m_axis_dout_tvalid  out  1  result valid
- m_axis_dout_tready  in  1  consumer ready
- m_axis_dout_tdata  out  2*WIDTH  {quotient[2W-1:W], remainder[W-1:0]}

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE, both capture flags 0, dout_tvalid 0, dout_tdata 0, counter 0.
- IDLE: each input channel independently; tready = ~captured flag for that channel. Beat accepted on tvalid & tready; data registered, flag set, tready drops next cycle.
- Channels may arrive in any order and any skew; both beats arriving in the same cycle is legal.
- IDLE -> CALC in the cycle after both flags are set (or at the edge where the second beat is accepted). Flags clear on entry to CALC.
- Pre-processing at CALC entry: signed mode takes magnitudes of both operands; records quotient sign = sign(x) XOR sign(y), remainder sign = sign(x).
- CALC: WIDTH iterations, one per cycle, counter 0..WIDTH-1. Each: shift partial remainder left bringing in next dividend MSB; if partial remainder >= |divisor|, subtract and shift 1 into quotient, else shift 0. Partial remainder held in WIDTH+1 bits.
- After last iteration -> DONE. Post-processing: negate quotient/remainder per recorded signs (signed mode only); result registered into dout_tdata, dout_tvalid = 1.
- Divisor zero (either mode): fixed latency unchanged; result forced to quotient = all ones, remainder = original dividend.
- Signed overflow (most-negative / -1): quotient = most-negative value (wrap), remainder = 0; no flag.
- Quotient truncates toward zero; remainder sign follows dividend.
- DONE: dout_tvalid and dout_tdata held stable until dout_tready; on handshake -> IDLE next cycle, dout_tvalid 0.
- Input tready is 0 in CALC and DONE; no early acceptance of the next operation.
- reset asserted in any state, including mid-CALC or DONE with pending result: next cycle is IDLE, result discarded, all outputs at reset values; input tready = 1 in the first cycle after reset deasserts.

## Timing
- Let E0 = edge where the second operand beat is accepted. CALC occupies WIDTH cycles after E0; dout_tvalid asserts in cycle E0+WIDTH+1 (33 for WIDTH=32).
- Result latency independent of operand values, signedness, and zero divisor.
- Input tready deasserts in the cycle after a channel's own accept.
- With dout_tready held 1: dout_tvalid high exactly one cycle; input tready reasserts the following cycle; throughput one op per WIDTH+2 cycles minimum.
- dout_tdata must not change while dout_tvalid=1 and dout_tready=0.

## Test plan
- Unsigned 100 / 7, both beats same cycle -> dout_tvalid at E0+33, tdata = 0x0000000E_00000002.
- Signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7 / -2 -> 0xFFFFFFFD, 0x00000001.
- Dividend accepted cycle 0, divisor cycle 5, 0xFFFFFFFF / 0x10 unsigned -> dividend tready low from cycle 1; valid at 5+33; tdata = 0x0FFFFFFF_0000000F.
- Divisor zero: 0x12345678 / 0 signed and unsigned -> quotient 0xFFFFFFFF, remainder 0x12345678, same 33-cycle latency; 0x80000000 / 0xFFFFFFFF signed -> 0x80000000, 0.
- Backpressure: dout_tready low 10 cycles after tvalid -> tvalid and tdata stable, input tready 0 throughout; release -> IDLE next cycle, back-to-back op returns correct result.
- reset pulse at CALC iteration 16 -> next cycle dout_tvalid 0, input tready 1 after deassert; subsequent 9 / 3 unsigned -> 0x00000003_00000000.

Source files
------------

// File: rtl/div_iter_axis.sv
// Iterative radix-2 restoring divider with AXI-stream dividend/divisor/dout channels.
// One operation in flight; fixed WIDTH-cycle compute latency regardless of operands.
module div_iter_axis #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tuser,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               m_axis_dout_tvalid,
  input  logic               m_axis_dout_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic [1:0]         dbg_state
);

  // Handshake: a beat transfers on any rising edge where tvalid & tready are both 1.
  // Producers hold tdata stable while tvalid=1 and tready=0; ready never depends on valid.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic             dvd_flag, dvs_flag;
  logic [WIDTH-1:0] dvd_q, dvs_q;
  logic             sgn_q;

  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic             q_neg, r_neg, div_zero;
  logic [WIDTH-1:0] orig_dvd;

  logic             dvd_acc, dvs_acc, start, last;
  logic [WIDTH-1:0] x_in, y_in, x_mag, y_mag;
  logic             sgn_in, x_neg, y_neg;
  logic [WIDTH:0]   rem_sh, rem_nx;
  logic [WIDTH-1:0] quo_nx, q_fin, r_fin;
  logic             ge;

  assign s_axis_dividend_tready = (state == IDLE) && !dvd_flag;
  assign s_axis_divisor_tready  = (state == IDLE) && !dvs_flag;
  assign dbg_state              = state;

  assign dvd_acc = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign dvs_acc = s_axis_divisor_tvalid  && s_axis_divisor_tready;
  assign start   = (state == IDLE) && (dvd_flag || dvd_acc) && (dvs_flag || dvs_acc);
  assign last    = (cnt == CW'(WIDTH - 1));

  // Operands come from the capture registers or straight off the bus when the
  // second beat lands, so CALC can begin at the accepting edge.
  always_comb begin
    x_in   = dvd_flag ? dvd_q : s_axis_dividend_tdata;
    sgn_in = dvd_flag ? sgn_q : s_axis_dividend_tuser;
    y_in   = dvs_flag ? dvs_q : s_axis_divisor_tdata;
    x_neg  = sgn_in && x_in[WIDTH-1];
    y_neg  = sgn_in && y_in[WIDTH-1];
    x_mag  = x_neg ? -x_in : x_in;
    y_mag  = y_neg ? -y_in : y_in;
  end

  always_comb begin
    rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvs_mag});
    rem_nx = ge ? (rem_sh - {1'b0, dvs_mag}) : rem_sh;
    quo_nx = {quo[WIDTH-2:0], ge};
    q_fin  = q_neg ? -quo_nx : quo_nx;
    r_fin  = r_neg ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
    if (div_zero) begin
      q_fin = '1;
      r_fin = orig_dvd;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last) state_nx = DONE;
      DONE:    if (m_axis_dout_tready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt                <= '0;
      dvd_flag           <= 1'b0;
      dvs_flag           <= 1'b0;
      dvd_q              <= '0;
      dvs_q              <= '0;
      sgn_q              <= 1'b0;
      rem                <= '0;
      quo                <= '0;
      dvs_mag            <= '0;
      q_neg              <= 1'b0;
      r_neg              <= 1'b0;
      div_zero           <= 1'b0;
      orig_dvd           <= '0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dvd_acc) begin
            dvd_q    <= s_axis_dividend_tdata;
            sgn_q    <= s_axis_dividend_tuser;
            dvd_flag <= 1'b1;
          end
          if (dvs_acc) begin
            dvs_q    <= s_axis_divisor_tdata;
            dvs_flag <= 1'b1;
          end
          if (start) begin
            dvd_flag <= 1'b0;
            dvs_flag <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            quo      <= x_mag;
            dvs_mag  <= y_mag;
            q_neg    <= x_neg ^ y_neg;
            r_neg    <= x_neg;
            div_zero <= (y_in == '0);
            orig_dvd <= x_in;
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            m_axis_dout_tdata  <= {q_fin, r_fin};
            m_axis_dout_tvalid <= 1'b1;
          end
        end
        DONE: begin
          if (m_axis_dout_tready) m_axis_dout_tvalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_axis.sv
// Self-checking bench for div_iter_axis: scripted operand pairs plus random ops,
// expected results queued at drive time and compared when dout handshakes.
module tb_div_iter_axis;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           s_axis_dividend_tvalid;
  logic           s_axis_dividend_tready;
  logic [W-1:0]   s_axis_dividend_tdata;
  logic           s_axis_dividend_tuser;
  logic           s_axis_divisor_tvalid;
  logic           s_axis_divisor_tready;
  logic [W-1:0]   s_axis_divisor_tdata;
  logic           m_axis_dout_tvalid;
  logic           m_axis_dout_tready;
  logic [2*W-1:0] m_axis_dout_tdata;
  logic [1:0]     dbg_state;

  logic [2*W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  div_iter_axis #(.WIDTH(W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
    .s_axis_dividend_tready (s_axis_dividend_tready),
    .s_axis_dividend_tdata  (s_axis_dividend_tdata),
    .s_axis_dividend_tuser  (s_axis_dividend_tuser),
    .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
    .s_axis_divisor_tready  (s_axis_divisor_tready),
    .s_axis_divisor_tdata   (s_axis_divisor_tdata),
    .m_axis_dout_tvalid     (m_axis_dout_tvalid),
    .m_axis_dout_tready     (m_axis_dout_tready),
    .m_axis_dout_tdata      (m_axis_dout_tdata),
    .dbg_state              (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sgn);
    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (y == '0) return {{W{1'b1}}, x};
    if (!sgn) return {x / y, x % y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    xs = x;
    ys = y;
    q  = xs / ys;
    r  = xs % ys;
    return {q, r};
  endfunction

  // driver: enters and leaves just after a rising edge; exits in cycle E0+1
  task automatic send_beats(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn,
                            input int skew);
    int dvd_at, dvs_at, last_at;
    dvd_at  = (skew < 0) ? -skew : 0;
    dvs_at  = (skew > 0) ? skew : 0;
    last_at = (dvd_at > dvs_at) ? dvd_at : dvs_at;
    for (int c = 0; c <= last_at; c++) begin
      s_axis_dividend_tvalid = (c == dvd_at);
      s_axis_dividend_tdata  = (c == dvd_at) ? x : W'($urandom);
      s_axis_dividend_tuser  = (c == dvd_at) ? sgn : ~sgn;
      s_axis_divisor_tvalid  = (c == dvs_at);
      s_axis_divisor_tdata   = (c == dvs_at) ? y : W'($urandom);
      @(negedge clk);
      if (c == 0) begin
        n_vec++;
        if (m_axis_dout_tvalid !== 1'b0) begin
          n_err++;
          $display("FAIL idle_tvalid: got %b want 0", m_axis_dout_tvalid);
        end
      end
      n_vec++;
      if (s_axis_dividend_tready !== (c <= dvd_at)) begin
        n_err++;
        $display("FAIL dividend_tready c=%0d: got %b want %b", c, s_axis_dividend_tready, c <= dvd_at);
      end
      n_vec++;
      if (s_axis_divisor_tready !== (c <= dvs_at)) begin
        n_err++;
        $display("FAIL divisor_tready c=%0d: got %b want %b", c, s_axis_divisor_tready, c <= dvs_at);
      end
      @(posedge clk); #1;
    end
    s_axis_dividend_tvalid = 1'b0;
    s_axis_divisor_tvalid  = 1'b0;
  endtask

  // waits out CALC, applies hold cycles of backpressure, pops and compares
  task automatic collect(input int hold, input string name);
    logic [2*W-1:0] held;
    logic [2*W-1:0] exp;
    bit calc_ok;
    calc_ok = 1'b1;
    m_axis_dout_tready = (hold == 0);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (m_axis_dout_tvalid !== 1'b0 || s_axis_dividend_tready !== 1'b0 ||
          s_axis_divisor_tready !== 1'b0) calc_ok = 1'b0;
      @(posedge clk); #1;
    end
    n_vec++;
    if (!calc_ok) begin
      n_err++;
      $display("FAIL %s calc_phase: early tvalid or input tready seen, want all 0", name);
    end
    @(negedge clk);
    n_vec++;
    if (m_axis_dout_tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL %s latency: tvalid=%b at E0+%0d, want 1", name, m_axis_dout_tvalid, W + 1);
    end
    held = m_axis_dout_tdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (h == hold - 1) m_axis_dout_tready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (m_axis_dout_tvalid !== 1'b1 || m_axis_dout_tdata !== held ||
          s_axis_dividend_tready !== 1'b0 || s_axis_divisor_tready !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold%0d: tvalid=%b tdata=%h rdy=%b%b want 1 %h 00", name, h,
                 m_axis_dout_tvalid, m_axis_dout_tdata, s_axis_dividend_tready,
                 s_axis_divisor_tready, held);
      end
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard: got %h with no expected entry", name, m_axis_dout_tdata);
    end else begin
      exp = exp_q.pop_front();
      if (m_axis_dout_tdata !== exp) begin
        n_err++;
        $display("FAIL %s result: got %h want %h", name, m_axis_dout_tdata, exp);
      end
    end
    @(posedge clk); #1;
    m_axis_dout_tready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn,
                        input int skew, input int hold, input logic [2*W-1:0] exp,
                        input string name);
    exp_q.push_back(exp);
    send_beats(x, y, sgn, skew);
    collect(hold, name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_axis_dividend_tvalid = 1'b0;
    s_axis_dividend_tdata  = '0;
    s_axis_dividend_tuser  = 1'b0;
    s_axis_divisor_tvalid  = 1'b0;
    s_axis_divisor_tdata   = '0;
    m_axis_dout_tready     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (m_axis_dout_tvalid !== 1'b0 || m_axis_dout_tdata !== '0 || dbg_state !== 2'd0 ||
        s_axis_dividend_tready !== 1'b1 || s_axis_divisor_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: tvalid=%b tdata=%h st=%0d rdy=%b%b want 0 0 0 11",
               m_axis_dout_tvalid, m_axis_dout_tdata, dbg_state,
               s_axis_dividend_tready, s_axis_divisor_tready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    run_op(32'd100, 32'd7, 1'b0, 0, 0, {32'h0000_000E, 32'h0000_0002}, "u100_7");
  endtask

  task automatic test_signed();
    run_op(-32'sd7, 32'd2, 1'b1, 0, 0, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, "s-7_2");
    run_op(32'd7, -32'sd2, 1'b1, 0, 0, {32'hFFFF_FFFD, 32'h0000_0001}, "s7_-2");
  endtask

  task automatic test_skew();
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 5, 0, {32'h0FFF_FFFF, 32'h0000_000F}, "skew_dvs_late");
    run_op(32'd1000, 32'd10, 1'b0, -3, 0, {32'd100, 32'd0}, "skew_dvd_late");
  endtask

  task automatic test_div_zero();
    run_op(32'h1234_5678, 32'h0, 1'b1, 0, 0, {32'hFFFF_FFFF, 32'h1234_5678}, "dz_signed");
    run_op(32'h1234_5678, 32'h0, 1'b0, 0, 0, {32'hFFFF_FFFF, 32'h1234_5678}, "dz_unsigned");
    run_op(32'h8765_4321, 32'h0, 1'b1, 2, 0, {32'hFFFF_FFFF, 32'h8765_4321}, "dz_neg");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, {32'h8000_0000, 32'h0}, "s_overflow");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, {32'h0, 32'h8000_0000}, "u_big_divisor");
  endtask

  task automatic test_backpressure();
    run_op(-32'sd100, 32'd7, 1'b1, 0, 10, {32'hFFFF_FFF2, 32'hFFFF_FFFE}, "bp_hold10");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, {32'h1, 32'h0}, "back_to_back");
  endtask

  task automatic test_reset_mid_calc();
    send_beats(32'd5000, 32'd3, 1'b0, 0);
    repeat (16) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_vec++;
    if (dbg_state !== 2'd1) begin
      n_err++;
      $display("FAIL mid_calc_state: got %0d want 1", dbg_state);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (m_axis_dout_tvalid !== 1'b0 || dbg_state !== 2'd0 ||
        s_axis_dividend_tready !== 1'b1 || s_axis_divisor_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_calc: tvalid=%b st=%0d rdy=%b%b want 0 0 11",
               m_axis_dout_tvalid, dbg_state, s_axis_dividend_tready, s_axis_divisor_tready);
    end
    @(posedge clk); #1;
    run_op(32'd9, 32'd3, 1'b0, 0, 0, {32'h0000_0003, 32'h0000_0000}, "after_reset_9_3");
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic sgn;
    for (int i = 0; i < 10; i++) begin
      x   = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : W'($urandom);
      y   = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      if ($urandom_range(0, 5) == 0) y = 32'hFFFF_FFFF;
      sgn = 1'($urandom_range(0, 1));
      run_op(x, y, sgn, $urandom_range(0, 6) - 3, $urandom_range(0, 2), model(x, y, sgn), "random");
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_skew();
    test_div_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    @(negedge clk);
    n_vec++;
    if (m_axis_dout_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL final_tvalid: got %b want 0", m_axis_dout_tvalid);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_queue: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
